// File: rtl/eth_e2e_pkg.sv
// rtl/eth_e2e_pkg.sv - shared types and constants for the MAC CSR bridge
package eth_e2e_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // Read data returned when a read gives up on waitrequest
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    // Default bound on cycles a single transfer may stall
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    // CSR bus widths
    localparam int CSR_DW = 32;
    localparam int CSR_AW = 16;

endpackage

// File: rtl/eth_csr_rd_mux.sv
// rtl/eth_csr_rd_mux.sv - selects one MAC port's readdata onto the bridge
module eth_csr_rd_mux
    import eth_e2e_pkg::*;
#(
    parameter int NUM_ETH = 4
) (
    input  logic [1:0]                data_sel,
    input  logic [NUM_ETH*CSR_DW-1:0] data_in,
    output logic [CSR_DW-1:0]         data_out
);

    // Pick the addressed port; out-of-range selects read as zero
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_ETH; i++) begin
            if (data_sel == 2'(i)) begin
                data_out = data_in[CSR_DW*i +: CSR_DW];
            end
        end
    end

endmodule

// File: rtl/eth_mac_csr_bridge.sv
// rtl/eth_mac_csr_bridge.sv - single-request bridge to per-port MAC Avalon-MM CSRs
module eth_mac_csr_bridge
    import eth_e2e_pkg::*;
#(
    parameter int NUM_ETH     = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      req_read,
    input  logic                      req_write,
    input  logic [1:0]                req_port,
    input  logic [CSR_AW-1:0]         req_addr,
    input  logic [CSR_DW-1:0]         req_wdata,
    output logic                      busy,
    output logic                      done,
    output logic [CSR_DW-1:0]         rdata,
    output logic                      timeout,
    output logic                      err_drop,
    input  logic                      err_clr,
    output logic [NUM_ETH-1:0]        csr_read,
    output logic [NUM_ETH-1:0]        csr_write,
    output logic [CSR_AW-1:0]         csr_address,
    output logic [CSR_DW-1:0]         csr_writedata,
    input  logic [NUM_ETH*CSR_DW-1:0] csr_readdata,
    input  logic [NUM_ETH-1:0]        csr_waitrequest
);

    localparam int              CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      NUM_ETH_L = 3'(NUM_ETH);

    state_t              state;
    logic [1:0]          port_q;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_ETH-1:0]  req_onehot;
    logic                wait_sel;
    logic [CSR_DW-1:0]   mux_rdata;
    logic                req_any;
    logic                req_ok;
    logic                accept;
    logic                drop_evt;
    logic                complete;
    logic                expire;

    eth_csr_rd_mux #(
        .NUM_ETH (NUM_ETH)
    ) u_rd_mux (
        .data_sel (port_q),
        .data_in  (csr_readdata),
        .data_out (mux_rdata)
    );

    // Decode the requested port into a strobe pattern
    always_comb begin
        req_onehot = '0;
        for (int i = 0; i < NUM_ETH; i++) begin
            req_onehot[i] = (req_port == 2'(i));
        end
    end

    // Waitrequest of the port owning the current transfer
    always_comb begin
        wait_sel = 1'b0;
        for (int i = 0; i < NUM_ETH; i++) begin
            if (port_q == 2'(i)) begin
                wait_sel = csr_waitrequest[i];
            end
        end
    end

    // A request is legal only if exactly one of read/write is set and the port exists
    assign req_any  = req_read | req_write;
    assign req_ok   = (req_read ^ req_write) && ({1'b0, req_port} < NUM_ETH_L);
    assign accept   = (state == IDLE) && req_ok;
    assign drop_evt = req_any && !accept;
    assign complete = (state != IDLE) && !wait_sel;
    assign expire   = (state != IDLE) && wait_sel && (cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    // Transfer FSM: latch request, hold strobe until accepted or timed out
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= IDLE;
            port_q        <= '0;
            cnt           <= '0;
            csr_read      <= '0;
            csr_write     <= '0;
            csr_address   <= '0;
            csr_writedata <= '0;
            rdata         <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        port_q        <= req_port;
                        csr_address   <= req_addr;
                        csr_writedata <= req_wdata;
                        csr_read      <= req_read  ? req_onehot : '0;
                        csr_write     <= req_write ? req_onehot : '0;
                        cnt           <= '0;
                        state         <= req_read ? RD : WR;
                    end
                end
                RD, WR: begin
                    if (complete || expire) begin
                        csr_read  <= '0;
                        csr_write <= '0;
                        done      <= 1'b1;
                        state     <= IDLE;
                        if (state == RD) begin
                            rdata <= complete ? mux_rdata : TIMEOUT_RDATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    csr_read  <= '0;
                    csr_write <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error event wins over a simultaneous clear
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            timeout  <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            if (expire) begin
                timeout <= 1'b1;
            end else if (err_clr) begin
                timeout <= 1'b0;
            end
            if (drop_evt) begin
                err_drop <= 1'b1;
            end else if (err_clr) begin
                err_drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_csr_bridge.sv
// tb/tb_eth_mac_csr_bridge.sv - directed self-checking bench for eth_mac_csr_bridge
module tb_eth_mac_csr_bridge;

    logic         clk = 1'b0;
    logic         arst;

    logic         req_read, req_write, err_clr;
    logic [1:0]   req_port;
    logic [15:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         busy, done, timeout, err_drop;
    logic [31:0]  rdata;
    logic [3:0]   csr_read, csr_write, csr_waitrequest;
    logic [15:0]  csr_address;
    logic [31:0]  csr_writedata;
    logic [127:0] csr_readdata;

    logic         b_req_read, b_req_write, b_err_clr;
    logic [1:0]   b_req_port;
    logic [15:0]  b_req_addr;
    logic [31:0]  b_req_wdata;
    logic         b_busy, b_done, b_timeout, b_err_drop;
    logic [31:0]  b_rdata;
    logic [1:0]   b_csr_read, b_csr_write, b_csr_waitrequest;
    logic [15:0]  b_csr_address;
    logic [31:0]  b_csr_writedata;
    logic [63:0]  b_csr_readdata;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n;

    always #5 clk = ~clk;

    eth_mac_csr_bridge #(.NUM_ETH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .arst(arst),
        .req_read(req_read), .req_write(req_write), .req_port(req_port),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .timeout(timeout), .err_drop(err_drop), .err_clr(err_clr),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .csr_waitrequest(csr_waitrequest)
    );

    eth_mac_csr_bridge #(.NUM_ETH(2), .TIMEOUT_CYC(16)) dut2 (
        .clk(clk), .arst(arst),
        .req_read(b_req_read), .req_write(b_req_write), .req_port(b_req_port),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .busy(b_busy), .done(b_done), .rdata(b_rdata),
        .timeout(b_timeout), .err_drop(b_err_drop), .err_clr(b_err_clr),
        .csr_read(b_csr_read), .csr_write(b_csr_write),
        .csr_address(b_csr_address), .csr_writedata(b_csr_writedata),
        .csr_readdata(b_csr_readdata), .csr_waitrequest(b_csr_waitrequest)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] p,
                         input logic [15:0] a, input logic [31:0] d);
        req_read  = rd;
        req_write = wr;
        req_port  = p;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        req_read = 0; req_write = 0; req_port = 0; req_addr = 0; req_wdata = 0; err_clr = 0;
        csr_waitrequest = 4'b0000; csr_readdata = '0;
        b_req_read = 0; b_req_write = 0; b_req_port = 0; b_req_addr = 0; b_req_wdata = 0; b_err_clr = 0;
        b_csr_waitrequest = 2'b00; b_csr_readdata = '0;
        tick(); tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_csr_read", csr_read, 0);
        chk("rst_csr_write", csr_write, 0);
        chk("rst_addr", csr_address, 0);
        chk("rst_wdata", csr_writedata, 0);
        chk("rst_flags", {timeout, err_drop}, 0);
        arst = 1'b0;
        tick();

        // read port 2, waitrequest released in the 4th strobe cycle
        csr_waitrequest = 4'b0100;
        csr_readdata[64 +: 32] = 32'h1234_5678;
        issue(1, 0, 2'd2, 16'h0040, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("rd2_strobe", csr_read, 4'b0100);
            chk("rd2_busy", busy, 1);
            if (k == 3) csr_waitrequest = 4'b0000;
            else tick();
        end
        chk("rd2_addr", csr_address, 16'h0040);
        tick();
        chk("rd2_strobe_off", csr_read, 0);
        chk("rd2_done", done, 1);
        chk("rd2_rdata", rdata, 32'h1234_5678);
        chk("rd2_busy_off", busy, 0);
        tick();
        chk("rd2_done_pulse", done, 0);

        // write port 1, no wait
        issue(0, 1, 2'd1, 16'h0010, 32'hCAFE_0001);
        chk("wr1_strobe", csr_write, 4'b0010);
        chk("wr1_no_read", csr_read, 0);
        chk("wr1_wdata", csr_writedata, 32'hCAFE_0001);
        chk("wr1_addr", csr_address, 16'h0010);
        tick();
        chk("wr1_strobe_off", csr_write, 0);
        chk("wr1_done", done, 1);
        chk("wr1_rdata_kept", rdata, 32'h1234_5678);

        // read port 0 with waitrequest stuck high -> timeout after 16 strobe cycles
        csr_waitrequest = 4'b0001;
        issue(1, 0, 2'd0, 16'h0004, 32'h0);
        n = 0;
        while (csr_read[0] && n < 40) begin
            n++;
            tick();
        end
        chk("to_strobe_cycles", n, 16);
        chk("to_done", done, 1);
        chk("to_flag", timeout, 1);
        chk("to_rdata", rdata, 32'hFFFF_FFFF);
        chk("to_busy", busy, 0);
        csr_waitrequest = 4'b0000;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", timeout, 0);

        // write request during busy read is dropped, read still completes
        csr_waitrequest = 4'b1000;
        csr_readdata[96 +: 32] = 32'hA5A5_0003;
        issue(1, 0, 2'd3, 16'h0080, 32'h0);
        issue(0, 1, 2'd1, 16'h0011, 32'h5555_5555);
        chk("drop_flag", err_drop, 1);
        chk("drop_no_write", csr_write, 0);
        chk("drop_read_kept", csr_read, 4'b1000);
        csr_waitrequest = 4'b0000;
        tick();
        chk("drop_rd_done", done, 1);
        chk("drop_rd_rdata", rdata, 32'hA5A5_0003);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("drop_clr", err_drop, 0);

        // async reset in the 2nd cycle of a write
        csr_waitrequest = 4'b0010;
        issue(0, 1, 2'd1, 16'h0020, 32'h0000_BEEF);
        chk("ar_strobe1", csr_write, 4'b0010);
        tick();
        chk("ar_strobe2", csr_write, 4'b0010);
        arst = 1'b1;
        #1;
        chk("ar_strobe_off", csr_write, 0);
        chk("ar_busy_off", busy, 0);
        tick();
        chk("ar_no_done", done, 0);
        arst = 1'b0;
        csr_waitrequest = 4'b0000;
        csr_readdata[0 +: 32] = 32'h0BAD_F00D;
        tick();
        chk("ar_no_done2", done, 0);
        issue(1, 0, 2'd0, 16'h0008, 32'h0);
        chk("ar_rd_strobe", csr_read, 4'b0001);
        tick();
        chk("ar_rd_done", done, 1);
        chk("ar_rd_rdata", rdata, 32'h0BAD_F00D);

        // back-to-back: new write accepted in the done cycle
        csr_readdata[64 +: 32] = 32'h0000_2222;
        issue(1, 0, 2'd2, 16'h0044, 32'h0);
        tick();
        chk("b2b_done", done, 1);
        issue(0, 1, 2'd0, 16'h0048, 32'h0000_3333);
        chk("b2b_wr_strobe", csr_write, 4'b0001);
        chk("b2b_busy", busy, 1);
        chk("b2b_rdata", rdata, 32'h0000_2222);
        chk("b2b_no_drop", err_drop, 0);
        tick();
        chk("b2b_wr_done", done, 1);

        // two-port instance: simultaneous read+write is dropped
        b_req_read = 1'b1; b_req_write = 1'b1; b_req_port = 2'd0;
        tick();
        b_req_read = 1'b0; b_req_write = 1'b0;
        chk("both_no_rd", b_csr_read, 0);
        chk("both_no_wr", b_csr_write, 0);
        chk("both_busy", b_busy, 0);
        chk("both_drop", b_err_drop, 1);
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        chk("both_clr", b_err_drop, 0);

        // two-port instance: port 3 out of range, with a simultaneous clear
        b_req_read = 1'b1; b_req_port = 2'd3; b_err_clr = 1'b1;
        tick();
        b_req_read = 1'b0; b_err_clr = 1'b0;
        chk("oor_no_rd", b_csr_read, 0);
        chk("oor_busy", b_busy, 0);
        chk("oor_drop_wins", b_err_drop, 1);
        tick();
        chk("oor_busy_later", b_busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
